// File: rtl/obj_manager_pkg.sv
// Shared definitions for the scrolling object manager: descriptor layout,
// slot count and the empty-type encoding.
package obj_manager_pkg;
  localparam int NUM_SLOTS = 5;

  localparam int VPOS_LSB  = 0;
  localparam int VPOS_W    = 10;
  localparam int HPOS_LSB  = VPOS_LSB + VPOS_W;
  localparam int HPOS_W    = 11;
  localparam int TYPE_LSB  = HPOS_LSB + HPOS_W;
  localparam int TYPE_W    = 2;
  localparam int FRAME_LSB = TYPE_LSB + TYPE_W;
  localparam int FRAME_W   = 3;
  localparam int DESC_W    = FRAME_LSB + FRAME_W;

  localparam logic [TYPE_W-1:0] TYPE_EMPTY = '0;

  typedef struct packed {
    logic [FRAME_W-1:0] frame;
    logic [TYPE_W-1:0]  otype;
    logic [HPOS_W-1:0]  hpos;
    logic [VPOS_W-1:0]  vpos;
  } obj_desc_t;

  typedef struct packed {
    logic [TYPE_W-1:0] otype;
    logic [VPOS_W-1:0] vpos;
  } spawn_t;
endpackage

// File: rtl/obj_slot.sv
// One object slot: loads a freshly spawned object, scrolls it left each frame
// tick, expires it once it would cross the left edge, and steps its animation.
module obj_slot
  import obj_manager_pkg::*;
#(
  parameter int SCREEN_WIDTH = 1024
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              tick,
  input  logic              anim,
  input  logic [3:0]        speed,
  input  logic              load,
  input  logic [TYPE_W-1:0] load_type,
  input  logic [VPOS_W-1:0] load_vpos,
  output logic [DESC_W-1:0] desc,
  output logic              active
);
  localparam logic [HPOS_W-1:0] SPAWN_HPOS = HPOS_W'(SCREEN_WIDTH - 1);

  obj_desc_t q;

  assign desc   = q;
  assign active = (q.otype != TYPE_EMPTY);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      q <= '0;
    end else if (load) begin
      q <= '{frame: '0, otype: load_type, hpos: SPAWN_HPOS, vpos: load_vpos};
    end else if (tick && active) begin
      // expiring clears the whole descriptor so nothing stale reaches display
      if (q.hpos < HPOS_W'(speed)) begin
        q <= '0;
      end else begin
        q.hpos <= q.hpos - HPOS_W'(speed);
        if (anim) q.frame <= q.frame + 1'b1;
      end
    end
  end
endmodule

// File: rtl/obj_manager.sv
// Object manager: frame tick from vsync, animation divider, spawn slot
// selection with a one-deep pending register for requests that hit a tick.
module obj_manager
  import obj_manager_pkg::*;
#(
  parameter int SCREEN_WIDTH = 1024,
  parameter int ANIM_LOG     = 3
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        vsync,
  input  logic        freeze,
  input  logic [3:0]  speed,
  input  logic        spawn_req,
  input  logic [1:0]  spawn_type,
  input  logic [9:0]  spawn_vpos,
  output logic [25:0] obj1,
  output logic [25:0] obj2,
  output logic [25:0] obj3,
  output logic [25:0] obj4,
  output logic [25:0] obj5,
  output logic [4:0]  active,
  output logic        spawn_ack,
  output logic        spawn_drop
);
  logic                 vsync_q, tick, tick_en, anim;
  logic [ANIM_LOG-1:0]  anim_cnt;
  logic                 pend_vld;
  spawn_t               pend, exec_req;
  logic                 exec, found, drop_nxt;
  logic [NUM_SLOTS-1:0] load;
  logic [NUM_SLOTS-1:0][DESC_W-1:0] desc;

  assign tick    = vsync_q & ~vsync;
  assign tick_en = tick & ~freeze;
  assign anim    = tick_en & (&anim_cnt);

  // spawns never share a cycle with a tick, so a slot freed by the tick is
  // already visible as empty when the deferred spawn executes
  always_comb begin
    exec     = 1'b0;
    exec_req = pend;
    if (!tick) begin
      if (pend_vld) begin
        exec = 1'b1;
      end else if (spawn_req) begin
        exec     = 1'b1;
        exec_req = '{otype: spawn_type, vpos: spawn_vpos};
      end
    end
  end

  always_comb begin
    load  = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (!found && !active[i]) begin
        found   = 1'b1;
        load[i] = exec && (exec_req.otype != TYPE_EMPTY);
      end
    end
  end

  assign drop_nxt = (exec && !(|load)) || (spawn_req && pend_vld);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      vsync_q    <= 1'b0;
      anim_cnt   <= '0;
      pend_vld   <= 1'b0;
      pend       <= '0;
      spawn_ack  <= 1'b0;
      spawn_drop <= 1'b0;
    end else begin
      vsync_q    <= vsync;
      spawn_ack  <= |load;
      spawn_drop <= drop_nxt;
      if (tick_en) anim_cnt <= anim_cnt + 1'b1;
      if (pend_vld) begin
        if (!tick) pend_vld <= 1'b0;
      end else if (spawn_req && tick) begin
        pend_vld <= 1'b1;
        pend     <= '{otype: spawn_type, vpos: spawn_vpos};
      end
    end
  end

  for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_slot
    obj_slot #(.SCREEN_WIDTH(SCREEN_WIDTH)) u_slot (
      .clock     (clock),
      .reset     (reset),
      .tick      (tick_en),
      .anim      (anim),
      .speed     (speed),
      .load      (load[g]),
      .load_type (exec_req.otype),
      .load_vpos (exec_req.vpos),
      .desc      (desc[g]),
      .active    (active[g])
    );
  end

  assign obj1 = desc[0];
  assign obj2 = desc[1];
  assign obj3 = desc[2];
  assign obj4 = desc[3];
  assign obj5 = desc[4];
endmodule

// File: doc/obj_manager.md
OBJ_MANAGER -- requirements
Module: obj_manager

Interface
REQ-001 Parameter SCREEN_WIDTH, 1024, horizontal pixel count; spawn hpos = SCREEN_WIDTH-1.
REQ-002 Parameter ANIM_LOG, 3, animation advances once every 2^ANIM_LOG frames.
REQ-003 clock  input  1  system pixel clock (65 MHz); all state on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 vsync  input  1  active-high VGA vsync; frame tick derived from its falling edge.
REQ-006 freeze  input  1  when high, frame ticks perform no scroll and no animation.
REQ-007 speed  input  4  pixels scrolled left per frame tick; 0 = stationary.
REQ-008 spawn_req  input  1  one-cycle spawn request.
REQ-009 spawn_type  input  2  object type; 0 is reserved for empty.
REQ-010 spawn_vpos  input  10  vertical position of spawned object.
REQ-011 obj1..obj5  output  26 each  descriptor {frame[25:23], type[22:21], hpos[20:10], vpos[9:0]} consumed by display.
REQ-012 active  output  5  bit i-1 high when slot i has type != 0.
REQ-013 spawn_ack  output  1  one-cycle pulse: request placed in a slot.
REQ-014 spawn_drop  output  1  one-cycle pulse: request discarded.

Function
REQ-015 vsync SHALL be registered once; frame tick = registered-previous high and current low, one cycle wide, one cycle after vsync falls.
REQ-016 On a frame tick with freeze low, each active slot SHALL subtract speed from hpos; if hpos < speed the slot SHALL be cleared to 26'h0 on that tick.
REQ-017 A 3-bit frame counter (ANIM_LOG bits) SHALL increment on each unfrozen tick; when it wraps to 0 every active slot's frame field SHALL increment modulo 8.
REQ-018 Inactive slots SHALL output exactly 26'h0.
REQ-019 Spawn SHALL write the lowest-index empty slot with {3'd0, spawn_type, SCREEN_WIDTH-1, spawn_vpos} in the cycle after spawn_req is sampled; spawn_ack pulses in that same cycle.
REQ-020 If spawn_req coincides with a frame tick, the request SHALL be held in a one-deep pending register and executed the following cycle.
REQ-021 A spawn_req arriving while a request is pending SHALL be dropped (spawn_drop), the pending one retained.
REQ-022 spawn_type 0, or all five slots active at execution time, SHALL produce spawn_drop and no slot change.
REQ-023 spawn_ack and spawn_drop SHALL never assert in the same cycle for the same request; pulses are exactly one cycle.
REQ-024 A slot freed by a tick SHALL be available to a spawn executing in the next cycle.
REQ-025 freeze SHALL not block spawning.
REQ-026 hpos arithmetic SHALL be 11-bit unsigned; no wrap-around value ever appears on an output.

Reset
REQ-027 While reset is low: obj1..obj5 = 0, active = 0, spawn_ack = 0, spawn_drop = 0, frame counter = 0, pending cleared, vsync register = 0.
REQ-028 Reset asserted mid-frame or with a pending spawn SHALL discard all state; first tick after release requires a fresh vsync falling edge.

Structure
REQ-029 Shared package SHALL hold descriptor field offsets/widths, NUM_SLOTS = 5, TYPE_EMPTY = 0.
REQ-030 Per-slot update (scroll, expire, animate, load) SHALL be one sub-module obj_slot, instantiated five times; slot selection and handshake remain in obj_manager.

Verification
REQ-031 Reset release, spawn type 1 vpos 384 -> next cycle obj1 = {0,1,1023,384}, active = 5'b00001, spawn_ack pulse.
REQ-032 speed 4, one slot active, 8 vsync falls -> hpos 1023->991, frame field 0->1 after 8th tick.
REQ-033 Five spawns then a sixth -> sixth yields spawn_drop, active = 5'b11111, outputs unchanged.
REQ-034 Slot hpos 3, speed 4, tick -> slot cleared to 0; spawn next cycle reuses that slot index.
REQ-035 spawn_req on tick cycle plus second spawn_req next cycle -> first executes one cycle late with ack, second dropped.
REQ-036 freeze high, 16 vsync falls -> no hpos/frame change; spawn still acknowledged; reset low mid-run -> all outputs 0 immediately.
